// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one subtractor cell plus a borrow flip-flop, LSB first,
// with a start/done handshake. Define SERIAL_SUB_ADD_MODE_EN to add a `mode` input (1 = add).
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_SUB_ADD_MODE_EN
   input  logic             mode,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sa_d;
   logic [WIDTH-1:0]   sb_q, sb_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               bf_q, bf_d;
   logic               borrow_q, borrow_d;
   logic               cellD;
   logic               cellBo;

`ifdef SERIAL_SUB_ADD_MODE_EN
   logic mode_q, mode_d;

   // In add mode the borrow flip-flop carries the carry instead.
   always_comb begin
      cellD = sa_q[0] ^ sb_q[0] ^ bf_q;
      if (mode_q)
         cellBo = (sa_q[0] & sb_q[0]) | ((sa_q[0] ^ sb_q[0]) & bf_q);
      else
         cellBo = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bf_q);
   end
`else
   always_comb begin
      cellD  = sa_q[0] ^ sb_q[0] ^ bf_q;
      cellBo = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bf_q);
   end
`endif

   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sr_d     = sr_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      bf_d     = bf_q;
      borrow_d = borrow_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode_d   = mode_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               bf_d    = 1'b0;
               cnt_d   = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
               mode_d  = mode;
`endif
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            sa_d = {1'b0, sa_q[WIDTH-1:1]};
            sb_d = {1'b0, sb_q[WIDTH-1:1]};
            sr_d = {cellD, sr_q[WIDTH-1:1]};
            bf_d = cellBo;
            // Counter holds at the last index so it never wraps within an operation.
            if (cnt_q == LAST) begin
               diff_d   = {cellD, sr_q[WIDTH-1:1]};
               borrow_d = cellBo;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         sr_q     <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         bf_q     <= 1'b0;
         borrow_q <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
         mode_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sr_q     <= sr_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         bf_q     <= bf_d;
         borrow_q <= borrow_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
         mode_q   <= mode_d;
`endif
      end
   end

   assign busy   = (state_q == SHIFT);
   assign done   = (state_q == DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8); the add-mode scenarios
// run only when SERIAL_SUB_ADD_MODE_EN is defined.
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       mode;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
`ifdef SERIAL_SUB_ADD_MODE_EN
      .mode   (mode),
`endif
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive operands on the falling edge; returns just after the accept edge E0.
   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges until done is seen (bounded) and the busy cycles on the way.
   task automatic waitDone(output int edges, output int busyCycles);
      edges      = 0;
      busyCycles = 0;
      while (!done && edges < 40) begin
         if (busy) busyCycles++;
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      checks++;
      if ({busy, done, borrow, diff} !== 11'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got busy=%b done=%b borrow=%b diff=%h expected all zero",
                  busy, done, borrow, diff);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int e, bc;
      applyStimulus(8'h5A, 8'h3C);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_busy_after_accept: got %b expected 1", busy);
      end
      waitDone(e, bc);
      checks++;
      if (e !== 8) begin
         errors++;
         $display("[TB] FAIL basic_latency: got %0d edges expected 8", e);
      end
      checks++;
      if (bc !== 8) begin
         errors++;
         $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", bc);
      end
      checks++;
      if (diff !== 8'h1E || borrow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_result: got diff=%h borrow=%b expected diff=1e borrow=0", diff, borrow);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_busy_with_done: got %b expected 0", busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_done_pulse_width: got %b expected 0", done);
      end
   endtask

   task automatic test_underflow();
      logic [7:0] av [3] = '{8'h03, 8'h00, 8'h00};
      logic [7:0] bv [3] = '{8'h05, 8'h00, 8'hFF};
      logic [7:0] ed [3] = '{8'hFE, 8'h00, 8'h01};
      logic       eb [3] = '{1'b1, 1'b0, 1'b1};
      int e, bc;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(av[i], bv[i]);
         waitDone(e, bc);
         checks++;
         if (done !== 1'b1 || diff !== ed[i] || borrow !== eb[i]) begin
            errors++;
            $display("[TB] FAIL underflow_%0d: got done=%b diff=%h borrow=%b expected done=1 diff=%h borrow=%b",
                     i, done, diff, borrow, ed[i], eb[i]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int e, bc;
      applyStimulus(8'h10, 8'h01);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      a     = 8'hFF;
      b     = 8'hFF;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      waitDone(e, bc);
      checks++;
      if (e !== 5) begin
         errors++;
         $display("[TB] FAIL busy_start_latency: got %0d remaining edges expected 5", e);
      end
      checks++;
      if (diff !== 8'h0F || borrow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL busy_start_result: got diff=%h borrow=%b expected diff=0f borrow=0", diff, borrow);
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL busy_start_no_second_op: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_back_to_back();
      int e, bc;
      int unstable;
      applyStimulus(8'h03, 8'h05);
      waitDone(e, bc);
      checks++;
      if (diff !== 8'hFE || borrow !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_first: got diff=%h borrow=%b expected diff=fe borrow=1", diff, borrow);
      end
      a     = 8'h80;
      b     = 8'h01;
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      e        = 1;
      unstable = 0;
      while (!done && e < 40) begin
         if (diff !== 8'hFE || borrow !== 1'b1) unstable++;
         @(posedge clk);
         #1;
         e++;
      end
      checks++;
      if (e !== 9) begin
         errors++;
         $display("[TB] FAIL b2b_spacing: got %0d cycles between done pulses expected 9", e);
      end
      checks++;
      if (unstable !== 0) begin
         errors++;
         $display("[TB] FAIL b2b_hold_previous: got %0d cycles with changed diff expected 0", unstable);
      end
      checks++;
      if (diff !== 8'h7F || borrow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_second: got diff=%h borrow=%b expected diff=7f borrow=0", diff, borrow);
      end
   endtask

   task automatic test_reset_midop();
      int e, bc;
      int doneSeen;
      applyStimulus(8'h5A, 8'h3C);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, borrow, diff} !== 11'd0) begin
         errors++;
         $display("[TB] FAIL midop_async_reset: got busy=%b done=%b borrow=%b diff=%h expected all zero",
                  busy, done, borrow, diff);
      end
      doneSeen = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done) doneSeen++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done) doneSeen++;
      end
      checks++;
      if (doneSeen !== 0) begin
         errors++;
         $display("[TB] FAIL midop_no_done: got %0d done cycles expected 0", doneSeen);
      end
      applyStimulus(8'h02, 8'h01);
      waitDone(e, bc);
      checks++;
      if (done !== 1'b1 || diff !== 8'h01 || borrow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midop_after_release: got done=%b diff=%h borrow=%b expected done=1 diff=01 borrow=0",
                  done, diff, borrow);
      end
   endtask

`ifdef SERIAL_SUB_ADD_MODE_EN
   task automatic test_add_mode();
      logic [7:0] av [3] = '{8'hFF, 8'h12, 8'h5A};
      logic [7:0] bv [3] = '{8'h01, 8'h34, 8'h3C};
      logic       mv [3] = '{1'b1, 1'b1, 1'b0};
      logic [7:0] ed [3] = '{8'h00, 8'h46, 8'h1E};
      logic       eb [3] = '{1'b1, 1'b0, 1'b0};
      int e, bc;
      for (int i = 0; i < 3; i++) begin
         mode = mv[i];
         applyStimulus(av[i], bv[i]);
         mode = ~mv[i];
         waitDone(e, bc);
         checks++;
         if (e !== 8 || diff !== ed[i] || borrow !== eb[i]) begin
            errors++;
            $display("[TB] FAIL add_mode_%0d: got edges=%0d diff=%h borrow=%b expected edges=8 diff=%h borrow=%b",
                     i, e, diff, borrow, ed[i], eb[i]);
         end
         @(posedge clk);
         #1;
      end
      mode = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      @(posedge clk);
      #1;
      test_start_while_busy();
      test_back_to_back();
      test_reset_midop();
`ifdef SERIAL_SUB_ADD_MODE_EN
      test_add_mode();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
